// File: rtl/stage_sequencer.sv
// stage_sequencer: program-load streaming and FETCH/DECODE/EXECUTE stage sequencing
module stage_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int PROG_DEPTH = 256,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [11:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W-1:0] load_addr,
  output logic [11:0]       load_instr,
  input  logic              load_start,
  input  logic              halt_req,
  input  logic              resume,
  output logic [1:0]        stage,
  output logic              pc_clr,
  output logic              loading,
  output logic              running,
  output logic              halted,
  output logic              instr_retired,
  output logic [CNT_W-1:0]  instr_count
);
  typedef enum logic [2:0] {LOAD_WAIT, S_F, S_D, S_E, HALT} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              pend;
  logic              accept;
  logic              done;
  assign accept        = (state == LOAD_WAIT) & load_valid;
  assign done          = accept & (load_last | (cnt == ADDR_W'(PROG_DEPTH - 1)));
  assign load_ready    = state == LOAD_WAIT;
  assign load_addr     = cnt;
  assign load_instr    = load_data;
  assign loading       = state == LOAD_WAIT;
  assign running       = (state == S_F) | (state == S_D) | (state == S_E);
  assign halted        = state == HALT;
  assign instr_retired = state == S_E;
  // LOAD only while a word is written; every idle or waiting cycle holds FETCH
  always_comb
    stage = accept ? 2'b00 : (state == S_D) ? 2'b10 : (state == S_E) ? 2'b11 : 2'b01;
  // state machine, load address counter, pending reload flag and retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD_WAIT;
      cnt         <= '0;
      pend        <= 1'b0;
      pc_clr      <= 1'b0;
      instr_count <= '0;
    end else begin
      pc_clr <= 1'b0;
      case (state)
        LOAD_WAIT: begin
          if (done) begin
            state       <= S_F;
            pc_clr      <= 1'b1;
            cnt         <= '0;
            instr_count <= '0;
          end else if (load_start) cnt <= '0;
          else if (accept) cnt <= cnt + 1'b1;
        end
        S_F: begin
          state <= S_D;
          pend  <= pend | load_start;
        end
        S_D: begin
          state <= S_E;
          pend  <= pend | load_start;
        end
        S_E: begin
          if (~&instr_count) instr_count <= instr_count + 1'b1;
          if (pend | load_start) begin
            state <= LOAD_WAIT;
            pend  <= 1'b0;
            cnt   <= '0;
          end else state <= halt_req ? HALT : S_F;
        end
        HALT: begin
          if (load_start) begin
            state <= LOAD_WAIT;
            pend  <= 1'b0;
            cnt   <= '0;
          end else if (resume) state <= S_F;
        end
        default: state <= LOAD_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed checks of load streaming, run loop, halt/resume, reload and reset
module tb_stage_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [11:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic [7:0]  load_addr;
  logic [11:0] load_instr;
  logic        load_start = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [1:0]  stage;
  logic        pc_clr;
  logic        loading;
  logic        running;
  logic        halted;
  logic        instr_retired;
  logic [15:0] instr_count;
  int checks = 0;
  int errors = 0;

  stage_sequencer dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_addr(load_addr),
    .load_instr(load_instr), .load_start(load_start), .halt_req(halt_req),
    .resume(resume), .stage(stage), .pc_clr(pc_clr), .loading(loading),
    .running(running), .halted(halted), .instr_retired(instr_retired),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [11:0] d, input logic last, input logic [7:0] addr);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    #1;
    chk("ld_stage", 32'(stage), 32'd0);
    chk("ld_addr", 32'(load_addr), 32'(addr));
    chk("ld_instr", 32'(load_instr), 32'(d));
    tick;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic idle(input logic [7:0] addr);
    #1;
    chk("gap_stage", 32'(stage), 32'd1);
    chk("gap_addr", 32'(load_addr), 32'(addr));
    chk("gap_ready", 32'(load_ready), 32'd1);
    tick;
  endtask

  task automatic check_reset;
    chk("rst_stage", 32'(stage), 32'd1);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_addr", 32'(load_addr), 32'd0);
    chk("rst_pcclr", 32'(pc_clr), 32'd0);
    chk("rst_loading", 32'(loading), 32'd1);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retired", 32'(instr_retired), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
  endtask

  task automatic first_f;
    #1;
    chk("f1_pcclr", 32'(pc_clr), 32'd1);
    chk("f1_stage", 32'(stage), 32'd1);
    chk("f1_running", 32'(running), 32'd1);
    chk("f1_ready", 32'(load_ready), 32'd0);
    chk("f1_count", 32'(instr_count), 32'd0);
    chk("f1_addr", 32'(load_addr), 32'd0);
  endtask

  initial begin
    #2;
    check_reset;
    #10 rst_n = 1'b1;
    tick;
    load_word(12'h123, 1'b0, 8'd0);
    load_word(12'h456, 1'b0, 8'd1);
    load_word(12'h789, 1'b1, 8'd2);
    first_f;
    tick;
    chk("run_d", 32'(stage), 32'd2);
    chk("run_pcclr", 32'(pc_clr), 32'd0);
    tick;
    chk("run_e", 32'(stage), 32'd3);
    chk("run_retired", 32'(instr_retired), 32'd1);
    tick;
    chk("run_f", 32'(stage), 32'd1);
    chk("run_cnt1", 32'(instr_count), 32'd1);
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    tick;
    chk("rl_e", 32'(stage), 32'd3);
    tick;
    chk("rl_loading", 32'(loading), 32'd1);
    chk("rl_cnt", 32'(instr_count), 32'd2);
    idle(8'd0);
    load_word(12'h123, 1'b0, 8'd0);
    idle(8'd1);
    load_word(12'h456, 1'b0, 8'd1);
    idle(8'd2);
    load_word(12'h789, 1'b1, 8'd2);
    first_f;
    for (int i = 0; i < 4; i++) begin
      tick;
      tick;
      tick;
    end
    chk("h_cnt4", 32'(instr_count), 32'd4);
    tick;
    chk("h_d5", 32'(stage), 32'd2);
    halt_req = 1'b1;
    tick;
    chk("h_e5", 32'(stage), 32'd3);
    tick;
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_stage", 32'(stage), 32'd1);
    chk("h_cnt5", 32'(instr_count), 32'd5);
    tick;
    chk("h_hold", 32'(halted), 32'd1);
    chk("h_hold_stage", 32'(stage), 32'd1);
    resume = 1'b1;
    tick;
    resume = 1'b0;
    halt_req = 1'b0;
    #1;
    chk("r_f", 32'(stage), 32'd1);
    chk("r_running", 32'(running), 32'd1);
    tick;
    chk("r_d", 32'(stage), 32'd2);
    tick;
    chk("r_e", 32'(stage), 32'd3);
    tick;
    chk("r_cnt6", 32'(instr_count), 32'd6);
    chk("r_f2", 32'(stage), 32'd1);
    tick;
    chk("ls_d", 32'(stage), 32'd2);
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    #1;
    chk("ls_e", 32'(stage), 32'd3);
    tick;
    chk("ls_loading", 32'(loading), 32'd1);
    chk("ls_addr", 32'(load_addr), 32'd0);
    chk("ls_cnt7", 32'(instr_count), 32'd7);
    for (int i = 0; i < 256; i++) load_word(12'(i * 7), 1'b0, 8'(i));
    first_f;
    load_valid = 1'b1;
    #1;
    chk("w257_ready", 32'(load_ready), 32'd0);
    chk("w257_stage", 32'(stage), 32'd1);
    load_valid = 1'b0;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    tick;
    tick;
    chk("mr_loading", 32'(loading), 32'd1);
    load_word(12'h111, 1'b0, 8'd0);
    load_word(12'h222, 1'b0, 8'd1);
    chk("mr_addr2", 32'(load_addr), 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("mr_post_addr", 32'(load_addr), 32'd0);
    chk("mr_post_loading", 32'(loading), 32'd1);
    load_start = 1'b1;
    load_word(12'hAAA, 1'b0, 8'd0);
    load_start = 1'b0;
    #1;
    chk("lsw_addr", 32'(load_addr), 32'd0);
    load_word(12'hBBB, 1'b1, 8'd0);
    first_f;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
